// File: rtl/bus_responder.sv
// bus_responder: tagged-bus memory target with latency-delayed burst reads and beat-counted line writes
module bus_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY = 4,
  parameter int BEATS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0]    bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
  output logic                         bus_reqack,
  output logic                         bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]    bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
  input  logic                         bus_respack,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [BUS_DATA_WIDTH-1:0]    load_data
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(BEATS);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, READ, WRITE} state_t;
  state_t state_q, state_d;
  logic [AW-BW-1:0] line_q, line_d;
  logic [BW-1:0] beat_q, beat_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
  logic ack_q, ack_d, cyc_q, cyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic last, accept, wr, fire, adv;
  always_comb begin
    nxt = beat_q + 1'b1;
    last = beat_q == BW'(BEATS - 1);
    accept = state_q == IDLE && bus_reqcyc;
    wr = state_q == WRITE && bus_reqcyc;
    fire = state_q == WAIT && cnt_q == CW'(LATENCY - 1);
    adv = state_q == READ && bus_respack;
    state_d = accept ? (bus_reqtag[BUS_TAG_WIDTH-1] ? WRITE : WAIT) :
              fire ? READ :
              ((adv || wr) && last) ? IDLE : state_q;
    line_d = accept ? bus_req[AW+2:3+BW] : line_q;
    tag_d = accept ? bus_reqtag : tag_q;
    cnt_d = accept ? '0 : state_q == WAIT ? cnt_q + 1'b1 : cnt_q;
    beat_d = accept ? '0 : (adv || wr) ? nxt : beat_q;
    ack_d = accept || wr;
    cyc_d = fire || (cyc_q && !(adv && last));
    resp_d = fire ? mem[{line_q, beat_q}] :
             adv ? (last ? '0 : mem[{line_q, nxt}]) : resp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      line_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      beat_q <= '0;
      ack_q <= 1'b0;
      cyc_q <= 1'b0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      beat_q <= beat_d;
      ack_q <= ack_d;
      cyc_q <= cyc_d;
      resp_q <= resp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (wr && !reset) mem[{line_q, beat_q}] <= bus_req;
  end
  assign bus_reqack = ack_q;
  assign bus_respcyc = cyc_q;
  assign bus_resp = resp_q;
  assign bus_resptag = tag_q;
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: table-driven and scoreboard checks of bus_responder reads, writes, stalls, reset and wrap
module tb_bus_responder;
  localparam int MW = 4096;
  localparam int LAT = 4;
  localparam int NB = 8;
  logic clk = 0;
  logic reset = 1;
  logic bus_reqcyc = 0;
  logic [63:0] bus_req = '0;
  logic [12:0] bus_reqtag = '0;
  logic bus_reqack, bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic bus_respack = 0;
  logic load_en = 0;
  logic [11:0] load_addr = '0;
  logic [63:0] load_data = '0;
  int checks = 0;
  int errors = 0;
  logic [63:0] model [MW];
  logic [63:0] q [$];
  typedef struct {
    logic [63:0] addr;
    logic [12:0] tag;
    int stall_beat;
    int stall_n;
    int abort_beat;
    logic [63:0] exp_first;
  } vec_t;
  vec_t vecs [7];
  bus_responder dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int widx(input logic [63:0] addr, input int i);
    logic [63:0] w;
    w = ((addr >> 3) & ~64'd7) | 64'(i);
    return int'(w % MW);
  endfunction
  task automatic preload(input int a, input logic [63:0] d);
    load_en = 1;
    load_addr = 12'(a);
    load_data = d;
    model[a] = d;
    tick();
    load_en = 0;
  endtask
  task automatic write_line(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base, input int stall_after);
    int acks;
    logic resp;
    acks = 0;
    resp = 0;
    bus_reqcyc = 1;
    bus_req = addr;
    bus_reqtag = tag;
    tick();
    chk("wr_addr_ack", 64'(bus_reqack), 1);
    for (int i = 0; i < NB; i++) begin
      bus_reqcyc = 1;
      bus_req = base + 64'(i);
      model[widx(addr, i)] = base + 64'(i);
      if (i == 2) begin
        load_en = 1;
        load_addr = 12'(widx(addr, i));
        load_data = 64'hBAD;
      end
      tick();
      load_en = 0;
      acks += int'(bus_reqack);
      resp |= bus_respcyc;
      if (i == stall_after) begin
        bus_reqcyc = 0;
        bus_req = 64'hFFFF;
        tick();
        acks += int'(bus_reqack);
        resp |= bus_respcyc;
      end
    end
    bus_reqcyc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acks += int'(bus_reqack);
      resp |= bus_respcyc;
    end
    chk("wr_beat_acks", 64'(acks), NB);
    chk("wr_no_resp", 64'(resp), 0);
  endtask
  task automatic read_line(input vec_t v, output logic [63:0] first);
    int lat, beat, waits;
    bit aborted;
    first = 'x;
    aborted = 0;
    for (int i = 0; i < NB; i++) q.push_back(model[widx(v.addr, i)]);
    bus_reqcyc = 1;
    bus_req = v.addr;
    bus_reqtag = v.tag;
    bus_respack = 0;
    tick();
    chk("rd_ack", 64'(bus_reqack), 1);
    bus_reqcyc = 0;
    lat = 0;
    while (!bus_respcyc && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) chk("rd_ack_pulse", 64'(bus_reqack), 0);
    end
    chk("rd_latency", 64'(lat), LAT);
    beat = 0;
    waits = 0;
    while (q.size() > 0 && !aborted) begin
      if (beat == v.abort_beat) begin
        bus_respack = 0;
        reset = 1;
        tick();
        chk("rst_respcyc", 64'(bus_respcyc), 0);
        chk("rst_reqack", 64'(bus_reqack), 0);
        chk("rst_resp", bus_resp, 0);
        reset = 0;
        q.delete();
        aborted = 1;
      end else begin
        chk("rd_cyc", 64'(bus_respcyc), 1);
        chk("rd_data", bus_resp, q[0]);
        chk("rd_tag", 64'(bus_resptag), 64'(v.tag));
        if (beat == 0) first = bus_resp;
        if (beat == v.stall_beat && waits < v.stall_n) begin
          bus_respack = 0;
          waits++;
        end else begin
          bus_respack = 1;
          void'(q.pop_front());
          beat++;
        end
        tick();
      end
    end
    bus_respack = 0;
    if (!aborted) chk("rd_end", 64'(bus_respcyc), 0);
    tick();
  endtask
  initial begin
    logic [63:0] f;
    vecs[0] = '{64'h200, 13'h0005, -1, 0, -1, 64'h1000};
    vecs[1] = '{64'h208, 13'h0011, -1, 0, -1, 64'h1000};
    vecs[2] = '{64'h200, 13'h0007, 2, 3, -1, 64'h1000};
    vecs[3] = '{64'h400, 13'h0123, -1, 0, -1, 64'hA0};
    vecs[4] = '{64'h200, 13'h0005, -1, 0, 5, 64'h1000};
    vecs[5] = '{64'h200, 13'h0006, 1, 1, -1, 64'h1000};
    vecs[6] = '{64'(MW * 8 + 'h200), 13'h0AAA, -1, 0, -1, 64'h1000};
    tick();
    tick();
    chk("reset_reqack", 64'(bus_reqack), 0);
    chk("reset_respcyc", 64'(bus_respcyc), 0);
    chk("reset_resp", bus_resp, 0);
    chk("reset_resptag", 64'(bus_resptag), 0);
    reset = 0;
    tick();
    for (int i = 0; i < NB; i++) preload('h40 + i, 64'h1000 + 64'(i));
    for (int i = 0; i < NB; i++) preload('h80 + i, 64'hDEAD0000 + 64'(i));
    write_line(64'h400, 13'h1003, 64'hA0, 4);
    for (int i = 0; i < 7; i++) begin
      read_line(vecs[i], f);
      chk($sformatf("vec%0d_first", i), f, vecs[i].exp_first);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
